// File: rtl/text_fetch_arbiter.sv
// Text-mode VGA fetch pipeline: turns pixel_x/pixel_y into a 1-bit colour with fixed latency,
// and shares the single-port character RAM between display fetch, a clear sweep and host writes.
//
// state      | meaning
// CLR_IDLE   | no sweep; free slots go to the host port
// CLR_SWEEP  | writing CLEAR_CHAR to clr_ptr on every free slot, 0..COLS*ROWS-1
module text_fetch_arbiter #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter int         LAT        = 3,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        video_active,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_req,
    input  logic [11:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic        wr_err,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic [11:0] cram_addr,
    output logic        cram_we,
    output logic [7:0]  cram_wdata,
    input  logic [7:0]  cram_rdata,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        color,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        video_active_out
);

    localparam logic [11:0] CELLS     = 12'(COLS * ROWS);
    localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);

    typedef enum logic {CLR_IDLE, CLR_SWEEP} clr_state_t;

    clr_state_t  clr_state;
    logic [11:0] clr_ptr;
    logic [11:0] fetch_addr;
    logic        fetch_slot;
    logic        clear_slot;
    logic        host_slot;

    logic [LAT-1:0] hs_d;
    logic [LAT-1:0] vs_d;
    logic [LAT-1:0] va_d;
    logic [3:0]     glyph_d1;
    logic [2:0]     xsub_d1;
    logic [2:0]     xsub_d2;
    logic [7:0]     font_hold;
    logic [7:0]     pix_row;

    logic unused_rdata_msb;
    assign unused_rdata_msb = cram_rdata[7];

    // row*80 + col as shifts: (row<<6) + (row<<4) + col
    assign fetch_addr = {pixel_y[9:4], 6'd0}
                      + {2'd0, pixel_y[9:4], 4'd0}
                      + {5'd0, pixel_x[9:3]};

    assign fetch_slot = video_active && (pixel_x[2:0] == 3'd0);
    assign clr_busy   = (clr_state == CLR_SWEEP);
    assign clear_slot = !fetch_slot && clr_busy;
    // A clr_req arriving while idle already outranks the host in its own cycle.
    assign host_slot  = !fetch_slot && !clr_busy && !clr_req && wr_req;

    always_comb begin
        cram_addr  = 12'd0;
        cram_we    = 1'b0;
        cram_wdata = 8'd0;
        wr_ack     = 1'b0;
        wr_err     = 1'b0;
        if (reset_n) begin
            if (fetch_slot) begin
                cram_addr = fetch_addr;
            end else if (clear_slot) begin
                cram_we    = 1'b1;
                cram_addr  = clr_ptr;
                cram_wdata = CLEAR_CHAR;
            end else if (host_slot) begin
                wr_ack = 1'b1;
                if (wr_addr < CELLS) begin
                    cram_we    = 1'b1;
                    cram_addr  = wr_addr;
                    cram_wdata = wr_data;
                end else begin
                    wr_err = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clr_state <= CLR_IDLE;
            clr_ptr   <= 12'd0;
        end else begin
            case (clr_state)
                CLR_IDLE: begin
                    if (clr_req) begin
                        clr_state <= CLR_SWEEP;
                        clr_ptr   <= 12'd0;
                    end
                end
                CLR_SWEEP: begin
                    if (clear_slot) begin
                        if (clr_ptr == LAST_CELL) begin
                            clr_state <= CLR_IDLE;
                            clr_ptr   <= 12'd0;
                        end else begin
                            clr_ptr <= clr_ptr + 12'd1;
                        end
                    end
                end
                default: begin
                    clr_state <= CLR_IDLE;
                    clr_ptr   <= 12'd0;
                end
            endcase
        end
    end

    // The RAM answers one cycle after the fetch, so the glyph row travels one stage behind it.
    assign font_addr = reset_n ? {cram_rdata[6:0], glyph_d1} : 11'd0;

    // On the load cycle the fresh font byte bypasses the hold register.
    assign pix_row = (xsub_d2 == 3'd0) ? font_data : font_hold;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_d      <= '1;
            vs_d      <= '1;
            va_d      <= '0;
            glyph_d1  <= 4'd0;
            xsub_d1   <= 3'd0;
            xsub_d2   <= 3'd0;
            font_hold <= 8'd0;
            color     <= 1'b0;
        end else begin
            hs_d     <= {hs_d[LAT-2:0], hsync_in};
            vs_d     <= {vs_d[LAT-2:0], vsync_in};
            va_d     <= {va_d[LAT-2:0], video_active};
            glyph_d1 <= pixel_y[3:0];
            xsub_d1  <= pixel_x[2:0];
            xsub_d2  <= xsub_d1;
            if (xsub_d2 == 3'd0)
                font_hold <= font_data;
            color <= va_d[1] & pix_row[3'd7 - xsub_d2];
        end
    end

    assign hsync_out        = hs_d[LAT-1];
    assign vsync_out        = vs_d[LAT-1];
    assign video_active_out = va_d[LAT-1];

endmodule

// File: tb/tb_text_fetch_arbiter.sv
// Directed bench for text_fetch_arbiter with behavioural character RAM and font ROM models.
module tb_text_fetch_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        video_active;
    logic [9:0]  pixel_x, pixel_y;
    logic        hsync_in, vsync_in;
    logic        wr_req;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack, wr_err;
    logic        clr_req, clr_busy;
    logic [11:0] cram_addr;
    logic        cram_we;
    logic [7:0]  cram_wdata;
    logic [7:0]  cram_rdata;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        color, hsync_out, vsync_out, video_active_out;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] cram [0:4095];
    logic [7:0] font [0:2047];

    always #5 clk = ~clk;

    text_fetch_arbiter dut (
        .clk(clk), .reset_n(reset_n), .video_active(video_active),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
        .clr_req(clr_req), .clr_busy(clr_busy),
        .cram_addr(cram_addr), .cram_we(cram_we), .cram_wdata(cram_wdata), .cram_rdata(cram_rdata),
        .font_addr(font_addr), .font_data(font_data),
        .color(color), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .video_active_out(video_active_out)
    );

    always @(posedge clk) begin
        if (cram_we) cram[cram_addr] <= cram_wdata;
        cram_rdata <= cram[cram_addr];
        font_data  <= font[font_addr];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        video_active = 1'b0; pixel_x = '0; pixel_y = '0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        video_active = 1'b1; wr_req = 1'b1; wr_addr = 12'd3; clr_req = 1'b1;
        repeat (3) cyc();
        #2;
        tests_run++;
        if ({color, hsync_out, vsync_out, video_active_out, wr_ack, wr_err, clr_busy, cram_we} !== 8'b0110_0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want %b",
                     {color, hsync_out, vsync_out, video_active_out, wr_ack, wr_err, clr_busy, cram_we}, 8'b0110_0000);
        end
        tests_run++;
        if (cram_addr !== 12'd0 || font_addr !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_addr: got cram_addr=%0d font_addr=%0d want 0 0", cram_addr, font_addr);
        end
        cyc();
        idle_inputs();
        reset_n = 1'b1;
        hsync_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2;
            tests_run++;
            if (hsync_out !== (k < 3)) begin
                tests_failed++;
                $display("FAIL reset_hsync_fill k=%0d: got %b want %b", k, hsync_out, (k < 3));
            end
            cyc();
        end
        hsync_in = 1'b1;
        repeat (4) cyc();
    endtask

    task automatic test_pixel_render();
        logic [15:0] exp_color = 16'b0001_1000_0000_0000;
        logic        hs_hist [0:19];
        logic        vs_hist [0:19];
        for (int k = 0; k < 20; k++) begin
            video_active = (k < 16);
            pixel_x      = (k < 16) ? 10'(k) : 10'd0;
            pixel_y      = 10'd0;
            hsync_in     = !(k >= 2 && k < 5);
            vsync_in     = (k != 4);
            hs_hist[k]   = hsync_in;
            vs_hist[k]   = vsync_in;
            #2;
            if (k >= 3) begin
                tests_run++;
                if (color !== ((k - 3 < 16) ? exp_color[18 - k] : 1'b0)) begin
                    tests_failed++;
                    $display("FAIL pixel_color p=%0d: got %b want %b", k - 3, color,
                             (k - 3 < 16) ? exp_color[18 - k] : 1'b0);
                end
                tests_run++;
                if ({hsync_out, vsync_out, video_active_out} !== {hs_hist[k-3], vs_hist[k-3], (k - 3 < 16)}) begin
                    tests_failed++;
                    $display("FAIL pixel_sync p=%0d: got %b want %b", k - 3,
                             {hsync_out, vsync_out, video_active_out}, {hs_hist[k-3], vs_hist[k-3], (k - 3 < 16)});
                end
            end
            cyc();
        end
        idle_inputs();
        repeat (3) cyc();
    endtask

    task automatic test_host_deferred();
        logic [7:0] exp_b = 8'h7C;
        video_active = 1'b1; pixel_y = 10'd16; pixel_x = 10'd0;
        wr_req = 1'b1; wr_addr = 12'd81; wr_data = 8'h42;
        #2;
        tests_run++;
        if ({wr_ack, cram_we} !== 2'b00 || cram_addr !== 12'd80) begin
            tests_failed++;
            $display("FAIL host_fetch_slot: got ack=%b we=%b addr=%0d want 0 0 80", wr_ack, cram_we, cram_addr);
        end
        cyc();
        pixel_x = 10'd1;
        #2;
        tests_run++;
        if ({wr_ack, wr_err, cram_we} !== 3'b101 || cram_addr !== 12'd81 || cram_wdata !== 8'h42) begin
            tests_failed++;
            $display("FAIL host_deferred_grant: got ack=%b err=%b we=%b addr=%0d data=%h want 1 0 1 81 42",
                     wr_ack, wr_err, cram_we, cram_addr, cram_wdata);
        end
        cyc();
        wr_req = 1'b0; pixel_x = 10'd2;
        #2;
        tests_run++;
        if (wr_ack !== 1'b0 || cram[81] !== 8'h42) begin
            tests_failed++;
            $display("FAIL host_written: got ack=%b cram81=%h want 0 42", wr_ack, cram[81]);
        end
        idle_inputs();
        repeat (4) cyc();
        for (int k = 0; k < 11; k++) begin
            video_active = (k < 8);
            pixel_x      = 10'(8 + k);
            pixel_y      = 10'd16;
            #2;
            if (k >= 3) begin
                tests_run++;
                if (color !== exp_b[10 - k]) begin
                    tests_failed++;
                    $display("FAIL render_b p=%0d: got %b want %b", k - 3, color, exp_b[10 - k]);
                end
            end
            cyc();
        end
        idle_inputs();
        repeat (3) cyc();
    endtask

    task automatic test_wr_err();
        wr_req = 1'b1; wr_addr = 12'd2400; wr_data = 8'h99;
        #2;
        tests_run++;
        if ({wr_ack, wr_err, cram_we} !== 3'b110) begin
            tests_failed++;
            $display("FAIL wr_err_2400: got ack=%b err=%b we=%b want 1 1 0", wr_ack, wr_err, cram_we);
        end
        cyc();
        wr_req = 1'b0;
        cyc();
        wr_req = 1'b1; wr_addr = 12'd2399; wr_data = 8'h33;
        #2;
        tests_run++;
        if ({wr_ack, wr_err, cram_we} !== 3'b101 || cram_addr !== 12'd2399) begin
            tests_failed++;
            $display("FAIL wr_ok_2399: got ack=%b err=%b we=%b addr=%0d want 1 0 1 2399",
                     wr_ack, wr_err, cram_we, cram_addr);
        end
        cyc();
        idle_inputs();
        cyc();
    endtask

    task automatic test_back_to_back();
        wr_req = 1'b1; wr_addr = 12'd10; wr_data = 8'h11;
        #2;
        tests_run++;
        if ({wr_ack, cram_we} !== 2'b11 || cram_addr !== 12'd10) begin
            tests_failed++;
            $display("FAIL b2b_first: got ack=%b we=%b addr=%0d want 1 1 10", wr_ack, cram_we, cram_addr);
        end
        cyc();
        wr_req = 1'b0;
        #2;
        tests_run++;
        if (wr_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_gap: got ack=%b want 0", wr_ack);
        end
        cyc();
        wr_req = 1'b1; wr_addr = 12'd11; wr_data = 8'h22;
        #2;
        tests_run++;
        if ({wr_ack, cram_we} !== 2'b11 || cram_addr !== 12'd11) begin
            tests_failed++;
            $display("FAIL b2b_second: got ack=%b we=%b addr=%0d want 1 1 11", wr_ack, cram_we, cram_addr);
        end
        cyc();
        idle_inputs();
        #2;
        tests_run++;
        if (cram[10] !== 8'h11 || cram[11] !== 8'h22) begin
            tests_failed++;
            $display("FAIL b2b_data: got %h %h want 11 22", cram[10], cram[11]);
        end
        cyc();
    endtask

    task automatic test_clear_sweep();
        int writes = 0, viol = 0, bad = 0, early_ack = 0, busy_gap = 0;
        int last_write = -1, fall_cyc = -1, ack_cyc = -1;
        logic [9:0] xc = 10'd1;
        cram[5] = 8'h00;
        video_active = 1'b1; pixel_y = 10'd0; pixel_x = xc;
        clr_req = 1'b1; wr_req = 1'b1; wr_addr = 12'd5; wr_data = 8'h55;
        #2;
        tests_run++;
        if (wr_ack !== 1'b0 || cram_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_wins: got ack=%b we=%b want 0 0", wr_ack, cram_we);
        end
        for (int i = 1; i < 4000; i++) begin
            cyc();
            xc      = (xc == 10'd639) ? 10'd0 : xc + 10'd1;
            pixel_x = xc;
            clr_req = (writes == 1200);
            if (ack_cyc >= 0) wr_req = 1'b0;
            #2;
            if (ack_cyc >= 0) break;
            if (cram_we && clr_busy) begin
                if (pixel_x[2:0] == 3'd0) viol++;
                if (cram_addr !== 12'(writes) || cram_wdata !== 8'h20) bad++;
                writes++;
                last_write = i;
            end
            if (!clr_busy && writes < 2400) busy_gap++;
            if (!clr_busy && fall_cyc < 0) fall_cyc = i;
            if (wr_ack) begin
                if (clr_busy) early_ack++;
                else ack_cyc = i;
            end
        end
        tests_run++;
        if (writes !== 2400 || bad !== 0) begin
            tests_failed++;
            $display("FAIL clear_writes: got writes=%0d bad=%0d want 2400 0", writes, bad);
        end
        tests_run++;
        if (viol !== 0 || busy_gap !== 0 || early_ack !== 0) begin
            tests_failed++;
            $display("FAIL clear_slots: got fetch_viol=%0d busy_gap=%0d early_ack=%0d want 0 0 0",
                     viol, busy_gap, early_ack);
        end
        tests_run++;
        if (fall_cyc !== last_write + 1) begin
            tests_failed++;
            $display("FAIL clear_busy_fall: got cycle %0d want %0d", fall_cyc, last_write + 1);
        end
        tests_run++;
        if (ack_cyc < 0 || ack_cyc > fall_cyc + 1) begin
            tests_failed++;
            $display("FAIL clear_host_ack: got cycle %0d want %0d or %0d", ack_cyc, fall_cyc, fall_cyc + 1);
        end
        idle_inputs();
        cyc();
        tests_run++;
        if (cram[5] !== 8'h55 || cram[0] !== 8'h20 || cram[2399] !== 8'h20) begin
            tests_failed++;
            $display("FAIL clear_contents: got %h %h %h want 55 20 20", cram[5], cram[0], cram[2399]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic reached = 1'b0;
        cram[1001] = 8'hEE;
        clr_req = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            cyc();
            clr_req = 1'b0;
            #2;
            if (cram_we && cram_addr == 12'd1000) begin
                reached = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!reached) begin
            tests_failed++;
            $display("FAIL mid_sweep_reach: got no write to 1000 want write to 1000");
        end
        cyc();
        reset_n = 1'b0; wr_req = 1'b1; wr_addr = 12'd7; wr_data = 8'h77;
        #2;
        tests_run++;
        if ({wr_ack, cram_we} !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_sweep_reset_cycle: got ack=%b we=%b want 0 0", wr_ack, cram_we);
        end
        cyc();
        #2;
        tests_run++;
        if ({color, hsync_out, vsync_out, video_active_out, wr_ack, wr_err, clr_busy, cram_we} !== 8'b0110_0000
            || cram_addr !== 12'd0 || font_addr !== 11'd0) begin
            tests_failed++;
            $display("FAIL mid_sweep_reset_state: got %b addr=%0d font=%0d want 01100000 0 0",
                     {color, hsync_out, vsync_out, video_active_out, wr_ack, wr_err, clr_busy, cram_we},
                     cram_addr, font_addr);
        end
        cyc();
        idle_inputs();
        reset_n = 1'b1;
        cyc();
        tests_run++;
        if (cram[1001] !== 8'hEE || cram[7] !== 8'h20) begin
            tests_failed++;
            $display("FAIL mid_sweep_aborted: got cram1001=%h cram7=%h want EE 20", cram[1001], cram[7]);
        end
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        #2;
        tests_run++;
        if ({clr_busy, cram_we} !== 2'b11 || cram_addr !== 12'd0) begin
            tests_failed++;
            $display("FAIL sweep_restart: got busy=%b we=%b addr=%0d want 1 1 0", clr_busy, cram_we, cram_addr);
        end
        repeat (5) cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) cram[i] = 8'h00;
        for (int i = 0; i < 2048; i++) font[i] = 8'h00;
        cram[0]            = 8'h41;
        cram[1]            = 8'h20;
        font[11'h41 << 4]  = 8'h18;
        font[11'h42 << 4]  = 8'h7C;
        test_reset();
        test_pixel_render();
        test_host_deferred();
        test_wr_err();
        test_back_to_back();
        test_clear_sweep();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/text_fetch_arbiter.md
# text_fetch_arbiter

Sequences the character-buffer RAM and font ROM for the text-mode VGA pipeline, sitting between `vga_core` and the RGB output stage. It turns the raw `pixel_x`/`pixel_y` stream into a 1-bit `color`, fixed-latency aligned with delayed sync outputs. It shares the single-port character RAM between display fetch (highest priority), a screen-clear sweep and a host write port.

## Interface
- COLS, 80, character columns per row
- ROWS, 30, character rows
- LAT, 3, fixed pixel-pipeline latency in clk cycles (not user-tunable; documents the alignment)
- CLEAR_CHAR, 8'h20, code written by the clear sweep
- clk  in  1  pixel clock (`clk_slow` domain); the only clock
- reset_n  in  1  synchronous, active-low reset
- video_active  in  1  from `vga_core`
- pixel_x, pixel_y  in  10 each  from `vga_core`
- hsync_in, vsync_in  in  1 each  from `vga_core`, active-low
- wr_req  in  1  host write request
- wr_addr  in  12  host cell address (row*COLS+col)
- wr_data  in  8  host character code
- wr_ack  out  1  one-cycle grant pulse
- wr_err  out  1  valid with wr_ack; 1 = address out of range, no write
- clr_req  in  1  one-cycle pulse starting a clear sweep
- clr_busy  out  1  sweep in progress
- cram_addr  out  12; cram_we  out  1; cram_wdata  out  8; cram_rdata  in  8  (1-cycle read latency)
- font_addr  out  11  {char[6:0], glyph_row[3:0]}; font_data  in  8  (1-cycle latency, bit 7 = leftmost pixel)
- color, hsync_out, vsync_out, video_active_out  out  1 each

## Operation
- Cell geometry: col = pixel_x[9:3], row = pixel_y[9:4], glyph_row = pixel_y[3:0]; fetch address = row*80+col, computed as (row<<6)+(row<<4)+col, 12 bits, max 2399.
- Fetch slot: cycle where video_active=1 and pixel_x[2:0]=0. Every other cycle is a free slot.
- Per-cycle RAM scheduler, priority order: FETCH (fetch slot; cram_we=0, cram_addr=fetch address) > CLEAR (clr_busy=1) > HOST (wr_req=1) > IDLE (cram_we=0).
- Pipeline: S0 issue cram read; S1 font_addr={cram_rdata[6:0], glyph_row delayed 1}; S2 font_data latched into 8-bit shift/hold register when delayed pixel_x[2:0]=0; S3 color = held bit [7 - pixel_x[2:0] delayed], forced 0 when delayed video_active=0.
- Sync path: hsync, vsync, video_active each delayed by exactly LAT registers.
- Clear FSM: IDLE -> SWEEP on clr_req. SWEEP writes CLEAR_CHAR to address ptr on each free slot, ptr increments 0..2399. After the write to 2399 -> IDLE, clr_busy falls the next cycle. clr_req while busy is ignored; the sweep does not restart.
- Host FSM: WAIT -> GRANT. In a HOST slot, address < COLS*ROWS: cram_we=1, cram_addr=wr_addr, cram_wdata=wr_data, wr_ack=1, wr_err=0. Address ≥ 2400: wr_ack=1, wr_err=1, cram_we=0.
- Host contract: hold wr_req/addr/data stable until wr_ack and deassert wr_req the cycle after. A request still high after the ack is a new request.
- Simultaneous clr_req and wr_req: clear wins; the host stalls until clr_busy=0.

## Timing
- Reset values: color=0, hsync_out=1, vsync_out=1, video_active_out=0, wr_ack=0, wr_err=0, clr_busy=0, cram_we=0, cram_addr=0, font_addr=0, all delay registers filled with reset levels.
- Reset mid-sweep aborts the sweep (ptr=0, clr_busy=0). Reset during a pending host request drops it with no ack.
- Latency: pixel presented at cycle t appears on color/syncs at t+3.
- wr_ack is combinational-to-registered: asserted in the same cycle as cram_we, one cycle wide.
- Worst-case host wait in active video: 1 cycle (fetch slot). During a sweep: up to 2400 free slots plus 1.
- Sweep duration fully in blanking: 2400 cycles. Active lines lose 1 of 8 slots.

## Test plan
- Char RAM preloaded with 'A' (0x41) at 0, font row 0 of 'A' = 8'h18. Pixel (0..7, 0) -> color 0,0,0,1,1,0,0,0 at t+3; hsync_out equals hsync_in delayed 3.
- Host write addr 81, data 0x42 held through active video with x[2:0]=0 -> ack deferred 1 cycle, written on the next free slot; cell (1,1) then renders 'B'.
- wr_addr=2400 -> wr_ack=1, wr_err=1, no cram_we in that cycle.
- clr_req during active video -> exactly 2400 writes of 0x20, none on fetch slots; clr_busy high throughout; concurrent wr_req acked only after clr_busy=0.
- reset_n low mid-sweep at ptr=1000 -> next cycle clr_busy=0, all outputs at reset values; new clr_req restarts from address 0.
- Two back-to-back host writes (wr_req dropped one cycle between) during blanking -> both acked, one cycle apart from each request.
